mem_line_responder: RTL

//  Memory-side responder for the cache-line read channel and word write channel driven by the
//  I/D cache memory arbiter. Serves a read request by fetching CACHE_LINE_WIDTH/DATA_WIDTH

---
 rtl/mem_line_responder_if.sv | 31 +++
 rtl/mem_line_responder.sv | 86 ++++++++
 2 files changed

// File: rtl/mem_line_responder_if.sv
// mem_line_responder_if: arbiter-side line read / word write channels plus the BRAM port.
// The master side is the environment (arbiter and BRAM), the slave side is the responder.
interface mem_line_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CACHE_LINE_WIDTH = 256,
    parameter int BRAM_AW = 14
);
    logic read_req;
    logic [ADDR_WIDTH-1:0] read_address;
    logic read_done;
    logic [CACHE_LINE_WIDTH-1:0] cache_line;
    logic write_valid;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0] write_data;
    logic [7:0] write_strobe;
    logic write_done;
    logic bram_en;
    logic [3:0] bram_we;
    logic [BRAM_AW-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_wdata;
    logic [DATA_WIDTH-1:0] bram_rdata;
    modport master (
        output read_req, read_address, write_valid, write_address, write_data, write_strobe, bram_rdata,
        input  read_done, cache_line, write_done, bram_en, bram_we, bram_addr, bram_wdata
    );
    modport slave (
        input  read_req, read_address, write_valid, write_address, write_data, write_strobe, bram_rdata,
        output read_done, cache_line, write_done, bram_en, bram_we, bram_addr, bram_wdata
    );
endinterface

// File: rtl/mem_line_responder.sv
// mem_line_responder: serves cache-line reads as BEATS consecutive BRAM words and single strobed word writes.
module mem_line_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CACHE_LINE_WIDTH = 256,
    parameter int BRAM_AW = 14
) (
    input logic clk,
    input logic rst_n,
    mem_line_responder_if.slave bus
);
    localparam int BEATS = CACHE_LINE_WIDTH / DATA_WIDTH;
    localparam int LB = $clog2(BEATS);
    typedef enum logic [2:0] {IDLE, RD, RD_LAST, RD_DONE, WR, WR_DONE, WAIT_REL} state_t;
    state_t state;
    logic [LB-1:0] beat;
    logic [LB-1:0] slot;
    logic unused_bits;
    assign slot = beat - 1'b1;
    assign unused_bits = ^{bus.read_address[ADDR_WIDTH-1:BRAM_AW+2], bus.read_address[LB+1:0],
                           bus.write_address[ADDR_WIDTH-1:BRAM_AW+2], bus.write_address[1:0],
                           bus.write_strobe[7:4]};
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            beat <= '0;
            bus.read_done <= 1'b0;
            bus.cache_line <= '0;
            bus.write_done <= 1'b0;
            bus.bram_en <= 1'b0;
            bus.bram_we <= 4'h0;
            bus.bram_addr <= '0;
            bus.bram_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.write_valid) begin
                        state <= WR;
                        bus.bram_en <= 1'b1;
                        bus.bram_we <= bus.write_strobe[3:0];
                        bus.bram_addr <= bus.write_address[BRAM_AW+1:2];
                        bus.bram_wdata <= bus.write_data;
                    end else if (bus.read_req) begin
                        state <= RD;
                        beat <= '0;
                        bus.bram_en <= 1'b1;
                        bus.bram_addr <= {bus.read_address[BRAM_AW+1:LB+2], LB'(0)};
                    end
                end
                RD: begin
                    // rdata trails the presented address by one beat
                    if (beat != '0)
                        bus.cache_line[DATA_WIDTH*int'(slot) +: DATA_WIDTH] <= bus.bram_rdata;
                    if (beat == LB'(BEATS-1)) begin
                        state <= RD_LAST;
                        bus.bram_en <= 1'b0;
                    end else begin
                        beat <= beat + 1'b1;
                        bus.bram_addr <= bus.bram_addr + 1'b1;
                    end
                end
                RD_LAST: begin
                    bus.cache_line[DATA_WIDTH*(BEATS-1) +: DATA_WIDTH] <= bus.bram_rdata;
                    bus.read_done <= 1'b1;
                    state <= RD_DONE;
                end
                RD_DONE: begin
                    bus.read_done <= 1'b0;
                    state <= WAIT_REL;
                end
                WR: begin
                    bus.bram_en <= 1'b0;
                    bus.bram_we <= 4'h0;
                    bus.write_done <= 1'b1;
                    state <= WR_DONE;
                end
                WR_DONE: begin
                    bus.write_done <= 1'b0;
                    state <= WAIT_REL;
                end
                WAIT_REL: state <= (!bus.read_req && !bus.write_valid) ? IDLE : WAIT_REL;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
